// File: rtl/ram_arb_pkg.sv
// Shared types for the scratch-RAM arbiter: FSM states, default geometry
// and the latched command word.
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Sized by the package defaults; ram_arbiter takes its defaults from the same constants.
  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with write enable and a registered read port
// that only updates on a read, so the last read value is held.
module ram_sp #(
  parameter int AW = 2,
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters sharing the scratch RAM: clears the
// array after reset, then runs each access as IDLE -> ACCESS -> DONE.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NREQ       = 2
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH+1)'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_ptr_q, clr_ptr_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  owner_q, owner_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;

  logic                  win;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    if (req[0] && req[1]) begin
      win = ~last_grant_q;
    end else begin
      win = ~req[0];
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      cmd_q        <= cmd_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    cmd_d        = cmd_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack          = '0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = cmd_q.addr;
    ram_wdata    = cmd_q.wdata;

    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_ptr_q[ADDR_WIDTH-1:0];
        ram_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (|req) begin
          owner_d       = win;
          grant_d       = '0;
          grant_d[win]  = 1'b1;
          cmd_d.we      = we[win];
          cmd_d.addr    = addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          cmd_d.wdata   = wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        ram_we  = cmd_q.we;
        ram_re  = ~cmd_q.we;
        state_d = DONE;
      end
      DONE: begin
        ack          = grant_q;
        last_grant_d = owner_q;
        grant_d      = '0;
        state_d      = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // A reset edge wins over any RAM operation scheduled for that same edge.
    if (reset) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  ram_sp #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk_2),
    .reset_i (reset),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (rdata)
  );

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
